// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Four-client round-robin arbiter in front of an SDRAM
//                controller. One burst is in flight at a time; the request
//                stage gives up after TIMEOUT cycles without an acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_done,
    input  logic [3:0]          cli_req,
    input  logic [3:0]          cli_we,
    input  logic [95:0]         cli_addr,
    input  logic [39:0]         cli_len,
    input  logic [4*DATA_W-1:0] cli_din,
    output logic [3:0]          cli_ack,
    output logic [DATA_W-1:0]   cli_dout,
    output logic [3:0]          cli_err,
    output logic                sdram_wr_req,
    output logic                sdram_rd_req,
    input  logic                sdram_wr_ack,
    input  logic                sdram_rd_ack,
    output logic [23:0]         sdram_wr_addr,
    output logic [23:0]         sdram_rd_addr,
    output logic [9:0]          sdram_wr_burst,
    output logic [9:0]          sdram_rd_burst,
    output logic [DATA_W-1:0]   sdram_din,
    input  logic [DATA_W-1:0]   sdram_dout,
    output logic [1:0]          gnt_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Timer value on which the request stage is abandoned.
    localparam logic [15:0] C_TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  id_q, id_d;
    logic [1:0]  last_gnt_q, last_gnt_d;
    logic        we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  err_q, err_d;

    logic        w_win_valid;
    logic [1:0]  w_win_id;
    logic        w_match_ack;

    // The acknowledge that belongs to the latched direction; the other one is ignored.
    assign w_match_ack = we_q ? sdram_wr_ack : sdram_rd_ack;

    // Round-robin winner: first requester after last_gnt, wrapping modulo 4.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = 2'd0;
        // Scan farthest-first so the nearest requester after last_gnt is kept.
        for (int k = 4; k >= 1; k--) begin
            if (cli_req[last_gnt_q + 2'(k)]) begin
                w_win_valid = 1'b1;
                w_win_id    = last_gnt_q + 2'(k);
            end
        end
    end

    // Next-state logic: grant latch, request timer, completion bookkeeping.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        len_d      = len_q;
        timer_d    = timer_q;
        err_d      = 4'd0;
        case (state_q)
            S_IDLE: begin
                timer_d = 16'd0;
                if (init_done && w_win_valid) begin
                    id_d    = w_win_id;
                    we_d    = cli_we[w_win_id];
                    addr_d  = cli_addr[int'(w_win_id)*24 +: 24];
                    len_d   = cli_len[int'(w_win_id)*10 +: 10];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (w_match_ack) begin
                    state_d = S_XFER;
                end else if (timer_q == C_TIMER_LAST) begin
                    err_d[id_q] = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_XFER: begin
                if (!w_match_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_gnt_d = id_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset leaves port 0 as the first round-robin winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            id_q       <= 2'd0;
            last_gnt_q <= 2'd3;
            we_q       <= 1'b0;
            addr_q     <= 24'd0;
            len_q      <= 10'd0;
            timer_q    <= 16'd0;
            err_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    // Output decode from the current state and latched grant.
    always_comb begin
        sdram_wr_req   = 1'b0;
        sdram_rd_req   = 1'b0;
        sdram_wr_addr  = 24'd0;
        sdram_rd_addr  = 24'd0;
        sdram_wr_burst = 10'd0;
        sdram_rd_burst = 10'd0;
        sdram_din      = '0;
        cli_ack        = 4'd0;
        if (state_q == S_REQ) begin
            if (we_q) begin
                sdram_wr_req   = 1'b1;
                sdram_wr_addr  = addr_q;
                sdram_wr_burst = len_q;
            end else begin
                sdram_rd_req   = 1'b1;
                sdram_rd_addr  = addr_q;
                sdram_rd_burst = len_q;
            end
        end
        if (state_q == S_XFER) begin
            cli_ack[id_q] = w_match_ack;
            sdram_din     = cli_din[int'(id_q)*DATA_W +: DATA_W];
        end
    end

    assign cli_dout = sdram_dout;
    assign cli_err  = err_q;
    assign gnt_id   = id_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Bench for sdram_port_arbiter. Plays the SDRAM controller,
//                predicts each grant from a round-robin reference and
//                checks every cycle of every transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                init_done;
    logic [3:0]          cli_req;
    logic [3:0]          cli_we;
    logic [95:0]         cli_addr;
    logic [39:0]         cli_len;
    logic [4*DATA_W-1:0] cli_din;
    logic [3:0]          cli_ack;
    logic [DATA_W-1:0]   cli_dout;
    logic [3:0]          cli_err;
    logic                sdram_wr_req, sdram_rd_req;
    logic                sdram_wr_ack, sdram_rd_ack;
    logic [23:0]         sdram_wr_addr, sdram_rd_addr;
    logic [9:0]          sdram_wr_burst, sdram_rd_burst;
    logic [DATA_W-1:0]   sdram_din, sdram_dout;
    logic [1:0]          gnt_id;
    logic                busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] rr_last;
    bit         opt_wrong;
    bit         opt_drop_init;
    bit         rand_next;
    int         opt_rst_beat;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_len(cli_len),
        .cli_din(cli_din), .cli_ack(cli_ack), .cli_dout(cli_dout), .cli_err(cli_err),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
        .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
        .sdram_din(sdram_din), .sdram_dout(sdram_dout),
        .gnt_id(gnt_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first requester after 'last', modulo 4.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(last) + k) % 4;
            if (req[idx]) return 2'(idx);
        end
        return last;
    endfunction

    task automatic set_acks(input logic we, input logic match, input logic other);
        sdram_wr_ack = we ? match : other;
        sdram_rd_ack = we ? other : match;
    endtask

    // Client-side inputs are free to change once a grant is latched.
    task automatic scramble();
        cli_req  = 4'($urandom);
        cli_we   = 4'($urandom);
        cli_addr = {$urandom, $urandom, $urandom};
        cli_len  = {8'($urandom), $urandom};
    endtask

    task automatic randomize_clients();
        cli_req  = 4'($urandom_range(1, 15));
        cli_we   = 4'($urandom);
        cli_addr = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) cli_len[i*10 +: 10] = 10'($urandom_range(1, 6));
    endtask

    // Quiet-output check; gnt_id only has a defined value right after reset.
    task automatic chk_quiet(input string tag, input bit with_gnt);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_req"}, sdram_wr_req, 0);
        chk({tag, "_rd_req"}, sdram_rd_req, 0);
        chk({tag, "_addr"}, {sdram_wr_addr, sdram_rd_addr}, 0);
        chk({tag, "_burst"}, {sdram_wr_burst, sdram_rd_burst}, 0);
        chk({tag, "_din"}, sdram_din, 0);
        chk({tag, "_ack"}, cli_ack, 0);
        chk({tag, "_err"}, cli_err, 0);
        if (with_gnt) chk({tag, "_gnt"}, gnt_id, 0);
    endtask

    // One transaction, entered at the falling edge of an IDLE cycle with the
    // client inputs in place; returns at the falling edge of the next IDLE.
    // The controller answers after 'delay' request cycles; its first ack
    // cycle is the handshake, followed by len data beats.
    task automatic do_txn(input int delay);
        logic [1:0]          id;
        logic                exp_we;
        logic [23:0]         exp_addr;
        logic [9:0]          exp_len;
        logic [3:0]          sv_req, sv_we;
        logic [95:0]         sv_addr;
        logic [39:0]         sv_len;
        int                  req_cycles;
        bit                  timed_out;
        id        = rr_pick(rr_last, cli_req);
        exp_we    = cli_we[id];
        exp_addr  = cli_addr[int'(id)*24 +: 24];
        exp_len   = cli_len[int'(id)*10 +: 10];
        sv_req    = cli_req;  sv_we  = cli_we;
        sv_addr   = cli_addr; sv_len = cli_len;
        timed_out = (delay >= TIMEOUT);
        req_cycles = timed_out ? TIMEOUT : delay + 1;
        @(posedge clk); #1;
        for (int c = 0; c < req_cycles; c++) begin
            if (c == delay) set_acks(exp_we, 1'b1, 1'b0);
            else            set_acks(exp_we, 1'b0, opt_wrong);
            scramble();
            @(negedge clk);
            chk("req_wr", sdram_wr_req, exp_we);
            chk("req_rd", sdram_rd_req, !exp_we);
            chk("req_gnt", gnt_id, id);
            chk("req_wr_addr", sdram_wr_addr, exp_we ? exp_addr : 24'd0);
            chk("req_rd_addr", sdram_rd_addr, exp_we ? 24'd0 : exp_addr);
            chk("req_wr_burst", sdram_wr_burst, exp_we ? exp_len : 10'd0);
            chk("req_rd_burst", sdram_rd_burst, exp_we ? 10'd0 : exp_len);
            chk("req_cli_ack", cli_ack, 0);
            chk("req_err", cli_err, 0);
            chk("req_busy", busy, 1);
            @(posedge clk); #1;
        end
        if (timed_out) begin
            set_acks(exp_we, 1'b0, 1'b0);
            @(negedge clk);
            chk("to_err", cli_err, 4'd1 << id);
            chk("to_req", {sdram_wr_req, sdram_rd_req}, 0);
            chk("to_busy", busy, 1);
        end else begin
            for (int b = 0; b < int'(exp_len); b++) begin
                set_acks(exp_we, 1'b1, 1'b0);
                scramble();
                cli_din    = {$urandom, $urandom};
                sdram_dout = DATA_W'($urandom);
                if (b == 0 && opt_drop_init) init_done = 1'b0;
                @(negedge clk);
                chk("xfer_req", {sdram_wr_req, sdram_rd_req}, 0);
                chk("xfer_ack", cli_ack, 4'd1 << id);
                chk("xfer_din", sdram_din, cli_din[int'(id)*DATA_W +: DATA_W]);
                chk("xfer_dout", cli_dout, sdram_dout);
                chk("xfer_gnt", gnt_id, id);
                chk("xfer_busy", busy, 1);
                if (b == opt_rst_beat) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    set_acks(1'b0, 1'b0, 1'b0);
                    @(negedge clk);
                    chk_quiet("rst_mid", 1'b1);
                    rst_n    = 1'b1;
                    cli_req  = sv_req;  cli_we  = sv_we;
                    cli_addr = sv_addr; cli_len = sv_len;
                    rr_last  = 2'd3;
                    return;
                end
                @(posedge clk); #1;
            end
            set_acks(exp_we, 1'b0, 1'b0);
            @(negedge clk);
            chk("tail_ack", cli_ack, 0);
            chk("tail_busy", busy, 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_busy", busy, 1);
            chk("done_err", cli_err, 0);
            chk("done_req", {sdram_wr_req, sdram_rd_req}, 0);
        end
        rr_last = id;
        if (rand_next) randomize_clients();
        else begin
            cli_req  = sv_req;  cli_we  = sv_we;
            cli_addr = sv_addr; cli_len = sv_len;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("idle", 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_acks(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_quiet("reset", 1'b1);
        rst_n   = 1'b1;
        rr_last = 2'd3;
    endtask

    initial begin
        rst_n = 1'b0; init_done = 1'b0;
        cli_req = 4'd0; cli_we = 4'd0; cli_addr = '0; cli_len = '0; cli_din = '0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_dout = '0;
        opt_wrong = 1'b0; opt_drop_init = 1'b0; rand_next = 1'b0; opt_rst_beat = -1;
        rr_last = 2'd3;
        do_reset();

        // Gating: nothing granted while init_done is low.
        cli_req = 4'b0011; cli_we = 4'b0011;
        cli_len = {10'd2, 10'd2, 10'd3, 10'd5};
        repeat (4) begin
            @(posedge clk); #1; @(negedge clk);
            chk_quiet("gate", 1'b0);
        end
        init_done = 1'b1;
        opt_drop_init = 1'b1;
        do_txn(1);
        opt_drop_init = 1'b0;
        repeat (3) begin
            @(posedge clk); #1; @(negedge clk);
            chk_quiet("gate_after", 1'b0);
        end

        // Single 8-beat write from client 0; ack arrives 3 cycles after request.
        init_done = 1'b1;
        cli_req = 4'b0001; cli_we = 4'b0001;
        cli_addr[23:0] = 24'h000100; cli_len[9:0] = 10'd8;
        do_txn(3);

        // Round-robin sweep with all four clients requesting.
        cli_req = 4'b0000;
        do_reset();
        cli_req = 4'b1111; cli_we = 4'b1010;
        cli_len = {10'd4, 10'd4, 10'd4, 10'd4};
        repeat (5) do_txn(1);

        // Timeout on a client 2 read, then ack exactly on the last allowed cycle.
        cli_req = 4'b0100; cli_we = 4'b0000;
        do_txn(TIMEOUT + 3);
        do_txn(TIMEOUT - 1);

        // Wrong-direction ack while a write waits.
        cli_req = 4'b0001; cli_we = 4'b0001; cli_len[9:0] = 10'd3;
        opt_wrong = 1'b1;
        do_txn(4);
        opt_wrong = 1'b0;

        // Reset on the third beat of an 8-beat burst.
        cli_len[9:0] = 10'd8;
        opt_rst_beat = 2;
        do_txn(2);
        opt_rst_beat = -1;
        cli_req = 4'b0011;
        do_txn(1);

        // Randomised traffic.
        rand_next = 1'b1;
        randomize_clients();
        for (int t = 0; t < 30; t++) begin
            int d;
            opt_wrong = bit'($urandom_range(0, 1));
            d = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, 6));
            do_txn(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
